// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned GRANT_CNT_W = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and counter signals of the shared memory port arbiter.
// slave : arbiter side (takes requests, drives the memory port and responses)
// master: environment side (requesters, memory model, performance readout)
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) ();
   import mem_arb_pkg::*;

   // instruction fetch requester
   logic                   i_req;
   logic [ADDR_WIDTH-1:0]  i_addr;
   logic                   i_ready;
   logic                   i_resp_valid;
   logic [DATA_WIDTH-1:0]  i_rdata;

   // data access requester
   logic                   d_req;
   logic                   d_we;
   logic [ADDR_WIDTH-1:0]  d_addr;
   logic [DATA_WIDTH-1:0]  d_wdata;
   logic                   d_ready;
   logic                   d_resp_valid;
   logic [DATA_WIDTH-1:0]  d_rdata;

   // shared memory port
   logic                   mem_req;
   logic                   mem_we;
   logic [ADDR_WIDTH-1:0]  mem_addr;
   logic [DATA_WIDTH-1:0]  mem_wdata;
   logic                   mem_rvalid;
   logic [DATA_WIDTH-1:0]  mem_rdata;

   // performance counters
   logic [GRANT_CNT_W-1:0] i_grant_cnt;
   logic [GRANT_CNT_W-1:0] d_grant_cnt;

   modport slave (
      input  i_req, i_addr,
      output i_ready, i_resp_valid, i_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_ready, d_resp_valid, d_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rvalid, mem_rdata,
      output i_grant_cnt, d_grant_cnt
   );

   modport master (
      output i_req, i_addr,
      input  i_ready, i_resp_valid, i_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_ready, d_resp_valid, d_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rvalid, mem_rdata,
      input  i_grant_cnt, d_grant_cnt
   );

endinterface : mem_port_arbiter_if

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch (I) and data (D) requesters.
// ARB_ROUND_ROBIN_EN defined  : on contention, grant the requester not granted last.
// ARB_ROUND_ROBIN_EN undefined: on contention, D always wins over I.
// A lone requester always wins.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic   i_req_i,
   input  logic   d_req_i,
   input  owner_t last_i,
   output owner_t win_o
);

`ifndef ARB_ROUND_ROBIN_EN
   // last-granted history has no effect with fixed priority
   logic unused_last;
   assign unused_last = ^last_i;
`endif

   // winner select
   always_comb begin
      win_o = OWN_NONE;
      if (i_req_i && d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
         win_o = (last_i == OWN_D) ? OWN_I : OWN_D;
`else
         win_o = OWN_D;
`endif
      end else if (d_req_i) begin
         win_o = OWN_D;
      end else if (i_req_i) begin
         win_o = OWN_I;
      end
   end

endmodule : mem_arb_pick

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (I) and data
// access (D). One access outstanding at a time: grant in IDLE (ready and
// mem_req in the same cycle), wait for mem_rvalid, route the response to
// the owner in that same cycle, then return to IDLE.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate grants on contention).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   state_t                 state_q, state_d;
   owner_t                 owner_q, owner_d;
   logic                   d_we_q, d_we_d;
   logic [GRANT_CNT_W-1:0] i_cnt_q, i_cnt_d;
   logic [GRANT_CNT_W-1:0] d_cnt_q, d_cnt_d;
   owner_t                 win;
   owner_t                 last_gnt;

   // ready/response/memory-port outputs are combinational by design (0-cycle grant,
   // same-cycle response), hence the _c names
   logic                   i_ready_c, d_ready_c;
   logic                   i_resp_valid_c, d_resp_valid_c;
   logic [DATA_WIDTH-1:0]  i_rdata_c, d_rdata_c;
   logic                   mem_req_c, mem_we_c;
   logic [ADDR_WIDTH-1:0]  mem_addr_c;
   logic [DATA_WIDTH-1:0]  mem_wdata_c;

`ifdef ARB_ROUND_ROBIN_EN
   owner_t                 last_q, last_d;
   assign last_gnt = last_q;
`else
   assign last_gnt = OWN_I;
`endif

   mem_arb_pick u_pick (
      .i_req_i (bus.i_req),
      .d_req_i (bus.d_req),
      .last_i  (last_gnt),
      .win_o   (win)
   );

   // state, owner and counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_NONE;
         d_we_q  <= 1'b0;
         i_cnt_q <= '0;
         d_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         d_we_q  <= d_we_d;
         i_cnt_q <= i_cnt_d;
         d_cnt_q <= d_cnt_d;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // last-granted requester; reset to I so the first contended grant goes to D
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= OWN_I;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   // next state, grant issue and response routing
   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      d_we_d         = d_we_q;
      i_cnt_d        = i_cnt_q;
      d_cnt_d        = d_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_d         = last_q;
`endif
      i_ready_c      = 1'b0;
      d_ready_c      = 1'b0;
      i_resp_valid_c = 1'b0;
      d_resp_valid_c = 1'b0;
      i_rdata_c      = '0;
      d_rdata_c      = '0;
      mem_req_c      = 1'b0;
      mem_we_c       = 1'b0;
      mem_addr_c     = '0;
      mem_wdata_c    = '0;

      case (state_q)
         ST_IDLE: begin
            if (win == OWN_D) begin
               d_ready_c   = 1'b1;
               mem_req_c   = 1'b1;
               mem_we_c    = bus.d_we;
               mem_addr_c  = bus.d_addr;
               mem_wdata_c = bus.d_wdata;
               d_we_d      = bus.d_we;
               d_cnt_d     = d_cnt_q + GRANT_CNT_W'(1);
               owner_d     = OWN_D;
               state_d     = ST_WAIT;
`ifdef ARB_ROUND_ROBIN_EN
               last_d      = OWN_D;
`endif
            end else if (win == OWN_I) begin
               i_ready_c   = 1'b1;
               mem_req_c   = 1'b1;
               mem_addr_c  = bus.i_addr;
               d_we_d      = 1'b0;
               i_cnt_d     = i_cnt_q + GRANT_CNT_W'(1);
               owner_d     = OWN_I;
               state_d     = ST_WAIT;
`ifdef ARB_ROUND_ROBIN_EN
               last_d      = OWN_I;
`endif
            end
         end

         ST_WAIT: begin
            if (bus.mem_rvalid) begin
               if (owner_q == OWN_I) begin
                  i_resp_valid_c = 1'b1;
                  i_rdata_c      = bus.mem_rdata;
               end else if (owner_q == OWN_D) begin
                  d_resp_valid_c = 1'b1;
                  d_rdata_c      = d_we_q ? '0 : bus.mem_rdata;
               end
               owner_d = OWN_NONE;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
         end
      endcase

      // nothing is granted or reported while reset is held
      if (reset) begin
         i_ready_c      = 1'b0;
         d_ready_c      = 1'b0;
         i_resp_valid_c = 1'b0;
         d_resp_valid_c = 1'b0;
         i_rdata_c      = '0;
         d_rdata_c      = '0;
         mem_req_c      = 1'b0;
         mem_we_c       = 1'b0;
         mem_addr_c     = '0;
         mem_wdata_c    = '0;
      end
   end

   // drive the interface
   assign bus.i_ready      = i_ready_c;
   assign bus.d_ready      = d_ready_c;
   assign bus.i_resp_valid = i_resp_valid_c;
   assign bus.d_resp_valid = d_resp_valid_c;
   assign bus.i_rdata      = i_rdata_c;
   assign bus.d_rdata      = d_rdata_c;
   assign bus.mem_req      = mem_req_c;
   assign bus.mem_we       = mem_we_c;
   assign bus.mem_addr     = mem_addr_c;
   assign bus.mem_wdata    = mem_wdata_c;
   assign bus.i_grant_cnt  = i_cnt_q;
   assign bus.d_grant_cnt  = d_cnt_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model with latency 3,
// a reference model of grants, and a scoreboard of expected responses.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int unsigned L = 3;

   typedef struct {
      owner_t      own;
      logic [31:0] data;
      int unsigned cyc;
   } ev_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc      = 0;

   mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // memory model: completes L cycles after the issue cycle
   logic [31:0] mem_arr [logic [31:0]];
   logic [31:0] mrdata_q = 32'h0;
   int unsigned mcnt     = 0;

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return a ^ 32'h5A5A_1234;
   endfunction

   assign bus.mem_rvalid = (mcnt == 1);
   assign bus.mem_rdata  = mrdata_q;

   always @(posedge clk) begin
      if (bus.mem_req) begin
         if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
         mrdata_q <= bus.mem_we ? 32'hFFFF_FFFF : rd(bus.mem_addr);
         mcnt     <= L;
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
      end
   end

   // reference model and scoreboard
   logic   m_wait = 1'b0;
   owner_t m_last = OWN_I;
   logic [31:0] m_icnt = 32'h0;
   logic [31:0] m_dcnt = 32'h0;
   ev_t    sbq[$];
   ev_t    glog[$];
   ev_t    rlog[$];

   function automatic owner_t exp_pick(input logic ir, input logic dr, input owner_t last);
      if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
         return (last == OWN_D) ? OWN_I : OWN_D;
`else
         return OWN_D;
`endif
      end
      if (dr) return OWN_D;
      if (ir) return OWN_I;
      return OWN_NONE;
   endfunction

   always @(negedge clk) begin
      owner_t win;
      ev_t    e;
      cyc++;
      if (reset) begin
         chk("rst_i_ready", 32'(bus.i_ready), 32'd0);
         chk("rst_d_ready", 32'(bus.d_ready), 32'd0);
         chk("rst_i_resp_valid", 32'(bus.i_resp_valid), 32'd0);
         chk("rst_d_resp_valid", 32'(bus.d_resp_valid), 32'd0);
         chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
         chk("rst_mem_addr", bus.mem_addr, 32'd0);
         m_wait = 1'b0;
         m_last = OWN_I;
         m_icnt = 32'h0;
         m_dcnt = 32'h0;
         sbq.delete();
      end else begin
         chk("i_grant_cnt", bus.i_grant_cnt, m_icnt);
         chk("d_grant_cnt", bus.d_grant_cnt, m_dcnt);
         if (!m_wait) begin
            win = exp_pick(bus.i_req, bus.d_req, m_last);
            chk("mem_req", 32'(bus.mem_req), 32'(win != OWN_NONE));
            chk("i_ready", 32'(bus.i_ready), 32'(win == OWN_I));
            chk("d_ready", 32'(bus.d_ready), 32'(win == OWN_D));
            chk("idle_i_resp_valid", 32'(bus.i_resp_valid), 32'd0);
            chk("idle_d_resp_valid", 32'(bus.d_resp_valid), 32'd0);
            chk("idle_i_rdata", bus.i_rdata, 32'd0);
            chk("idle_d_rdata", bus.d_rdata, 32'd0);
            if (win == OWN_I) begin
               chk("i_mem_addr", bus.mem_addr, bus.i_addr);
               chk("i_mem_we", 32'(bus.mem_we), 32'd0);
               sbq.push_back('{OWN_I, rd(bus.i_addr), cyc});
               m_icnt = m_icnt + 32'd1;
            end else if (win == OWN_D) begin
               chk("d_mem_addr", bus.mem_addr, bus.d_addr);
               chk("d_mem_we", 32'(bus.mem_we), 32'(bus.d_we));
               chk("d_mem_wdata", bus.mem_wdata, bus.d_wdata);
               sbq.push_back('{OWN_D, bus.d_we ? 32'h0 : rd(bus.d_addr), cyc});
               m_dcnt = m_dcnt + 32'd1;
            end else begin
               chk("idle_mem_addr", bus.mem_addr, 32'd0);
               chk("idle_mem_wdata", bus.mem_wdata, 32'd0);
               chk("idle_mem_we", 32'(bus.mem_we), 32'd0);
            end
            if (win != OWN_NONE) begin
               glog.push_back('{win, 32'h0, cyc});
               m_wait = 1'b1;
               m_last = win;
            end
         end else begin
            chk("wait_i_ready", 32'(bus.i_ready), 32'd0);
            chk("wait_d_ready", 32'(bus.d_ready), 32'd0);
            chk("wait_mem_req", 32'(bus.mem_req), 32'd0);
            chk("wait_mem_addr", bus.mem_addr, 32'd0);
            chk("wait_mem_wdata", bus.mem_wdata, 32'd0);
            if (bus.mem_rvalid) begin
               if (sbq.size() == 0) begin
                  chk("sb_empty", 32'd1, 32'd0);
               end else begin
                  e = sbq.pop_front();
                  chk("resp_i_valid", 32'(bus.i_resp_valid), 32'(e.own == OWN_I));
                  chk("resp_d_valid", 32'(bus.d_resp_valid), 32'(e.own == OWN_D));
                  chk("resp_i_rdata", bus.i_rdata, (e.own == OWN_I) ? e.data : 32'h0);
                  chk("resp_d_rdata", bus.d_rdata, (e.own == OWN_D) ? e.data : 32'h0);
                  chk("resp_latency", cyc - e.cyc, L);
               end
               if (bus.i_resp_valid) rlog.push_back('{OWN_I, bus.i_rdata, cyc});
               if (bus.d_resp_valid) rlog.push_back('{OWN_D, bus.d_rdata, cyc});
               m_wait = 1'b0;
            end else begin
               chk("wait_i_resp_valid", 32'(bus.i_resp_valid), 32'd0);
               chk("wait_d_resp_valid", 32'(bus.d_resp_valid), 32'd0);
               chk("wait_i_rdata", bus.i_rdata, 32'd0);
               chk("wait_d_rdata", bus.d_rdata, 32'd0);
            end
         end
      end
   end

   task automatic do_reset();
      reset     = 1'b1;
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      glog.delete();
      rlog.delete();
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int k = 0; k < 50 && !done; k++) begin
         tick();
         if (!m_wait && sbq.size() == 0) done = 1'b1;
      end
      if (!done) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int unsigned n_exp;
      bit          drop;
      logic        gi, gd;

      bus.i_req   = 1'b0;
      bus.i_addr  = 32'h0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h0;
      bus.d_wdata = 32'h0;
      mem_arr[32'h10] = 32'h0050_0093;

      // reset then idle
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("ri_mem_req", 32'(bus.mem_req), 32'd0);
         chk("ri_ready", 32'({bus.i_ready, bus.d_ready}), 32'd0);
         chk("ri_resp", 32'({bus.i_resp_valid, bus.d_resp_valid}), 32'd0);
         chk("ri_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
         chk("ri_cnt", bus.i_grant_cnt | bus.d_grant_cnt, 32'd0);
      end
      tick();

      // lone fetch
      do_reset();
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h10;
      @(negedge clk);
      chk("lf_i_ready", 32'(bus.i_ready), 32'd1);
      chk("lf_mem_req", 32'(bus.mem_req), 32'd1);
      chk("lf_mem_addr", bus.mem_addr, 32'h10);
      chk("lf_mem_we", 32'(bus.mem_we), 32'd0);
      tick();
      bus.i_req = 1'b0;
      wait_idle();
      chk("lf_nresp", 32'(rlog.size()), 32'd1);
      if (rlog.size() > 0 && glog.size() > 0) begin
         chk("lf_owner", 32'(rlog[0].own), 32'(OWN_I));
         chk("lf_rdata", rlog[0].data, 32'h0050_0093);
         chk("lf_latency", rlog[0].cyc - glog[0].cyc, 32'd3);
      end
      @(negedge clk);
      chk("lf_i_cnt", bus.i_grant_cnt, 32'd1);
      chk("lf_d_cnt", bus.d_grant_cnt, 32'd0);
      tick();

      // simultaneous requests
      do_reset();
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h20;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h200;
`ifdef ARB_ROUND_ROBIN_EN
      n_exp = 4;
      drop  = 1'b0;
`else
      n_exp = 2;
      drop  = 1'b1;
`endif
      for (int k = 0; k < 200 && glog.size() < int'(n_exp); k++) begin
         @(negedge clk);
         gi = bus.i_ready;
         gd = bus.d_ready;
         tick();
         if (drop && gi) bus.i_req = 1'b0;
         if (drop && gd) bus.d_req = 1'b0;
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      wait_idle();
      chk("sim_ngrants", 32'(glog.size()), n_exp);
      for (int k = 0; k < int'(n_exp); k++) begin
         if (glog.size() > k)
            chk("sim_order", 32'(glog[k].own), (k % 2 == 0) ? 32'(OWN_D) : 32'(OWN_I));
      end
      if (glog.size() > 1 && rlog.size() > 0)
         chk("sim_i_after_d_resp", glog[1].cyc - rlog[0].cyc, 32'd1);
      @(negedge clk);
      chk("sim_d_cnt", bus.d_grant_cnt, n_exp / 2);
      chk("sim_i_cnt", bus.i_grant_cnt, n_exp / 2);
      tick();

      // D write ack, then read back
      do_reset();
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h40;
      bus.d_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("wr_d_ready", 32'(bus.d_ready), 32'd1);
      chk("wr_mem_we", 32'(bus.mem_we), 32'd1);
      chk("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("wr_mem_addr", bus.mem_addr, 32'h40);
      tick();
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      wait_idle();
      chk("wr_nresp", 32'(rlog.size()), 32'd1);
      if (rlog.size() > 0) begin
         chk("wr_owner", 32'(rlog[0].own), 32'(OWN_D));
         chk("wr_rdata", rlog[0].data, 32'h0);
      end
      bus.d_req = 1'b1;
      tick();
      bus.d_req = 1'b0;
      wait_idle();
      if (rlog.size() > 1) chk("rb_rdata", rlog[1].data, 32'hDEAD_BEEF);
      else chk("rb_nresp", 32'(rlog.size()), 32'd2);

      // reset mid-access
      do_reset();
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h80;
      @(negedge clk);
      chk("rm_i_ready", 32'(bus.i_ready), 32'd1);
      tick();
      bus.i_req = 1'b0;
      reset     = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rm_no_i_resp", 32'(bus.i_resp_valid), 32'd0);
         chk("rm_i_cnt", bus.i_grant_cnt, 32'd0);
      end
      tick();
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h300;
      @(negedge clk);
      chk("rm_d_ready", 32'(bus.d_ready), 32'd1);
      chk("rm_d_cnt", bus.d_grant_cnt, 32'd0);
      tick();
      bus.d_req = 1'b0;
      wait_idle();
      chk("rm_nresp", 32'(rlog.size()), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_mem_port_arbiter
